// File: rtl/button_emulator_if.sv
// Command and status bundle of the push-button emulator.
// The master side issues level/bounce commands; the slave side is the emulator.
interface button_emulator_if #(
    parameter int BOUNCE_MAX = 8
);
    localparam int NB = $clog2(BOUNCE_MAX + 1);

    logic          i_valid;
    logic          i_level;
    logic [NB-1:0] i_n_bounces;
    logic          o_ready;
    logic          o_out;
    logic          o_busy;
    logic          o_done;

    modport master (
        output i_valid,
        output i_level,
        output i_n_bounces,
        input  o_ready,
        input  o_out,
        input  o_busy,
        input  o_done
    );

    modport slave (
        input  i_valid,
        input  i_level,
        input  i_n_bounces,
        output o_ready,
        output o_out,
        output o_busy,
        output o_done
    );
endinterface

// File: rtl/button_emulator.sv
// Mechanical push-button emulator: on command it toggles its line through a
// number of glitch pairs with LFSR or fixed gaps, lands on the requested
// level, holds it for a settle period and then pulses done for one cycle.
module button_emulator #(
    parameter int          BOUNCE_MAX    = 8,
    parameter int          GAP_LOG2      = 6,
    parameter int          SETTLE_CYCLES = 2048,
    parameter bit          RANDOM        = 1'b1,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter bit          RESET_LEVEL   = 1'b0
) (
    input logic              clk,
    input logic              i_reset,
    button_emulator_if.slave bus
);
    localparam int NB = $clog2(BOUNCE_MAX + 1);
    localparam int TW = NB + 1;
    localparam int GW = GAP_LOG2 + 1;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BOUNCE = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [NB-1:0] N_MAX       = NB'(BOUNCE_MAX);
    localparam logic [GW-1:0] GAP_FIXED   = GW'(1) << GAP_LOG2;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES);

    logic [1:0]    state;
    logic          out_q;
    logic [15:0]   lfsr;
    logic [GW-1:0] gap_cnt;
    logic [TW-1:0] toggle_cnt;
    logic [SW-1:0] settle_cnt;

    logic [15:0]   lfsr_next;
    logic [GW-1:0] next_gap;
    logic [NB-1:0] n_clamped;
    logic [TW-1:0] toggle_load;
    logic          accept;

    // Next LFSR step (x^16+x^14+x^13+x^11+1) and the gap the current value yields
    always_comb begin
        lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        if (RANDOM) begin
            next_gap = {1'b0, lfsr[GAP_LOG2-1:0]} + GW'(1);
        end else begin
            next_gap = GAP_FIXED;
        end
    end

    // Command decode: clamp the bounce count and derive the toggle total whose parity lands on the target
    always_comb begin
        accept      = bus.i_valid && (state == IDLE);
        n_clamped   = (bus.i_n_bounces > N_MAX) ? N_MAX : bus.i_n_bounces;
        toggle_load = {n_clamped, 1'b0} + TW'(bus.i_level != out_q);
    end

    // Main FSM: accept, bounce through the toggles, settle, pulse done
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state      <= IDLE;
            out_q      <= RESET_LEVEL;
            lfsr       <= LFSR_SEED;
            gap_cnt    <= '0;
            toggle_cnt <= '0;
            settle_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        toggle_cnt <= toggle_load;
                        if (toggle_load == '0) begin
                            state      <= SETTLE;
                            settle_cnt <= SETTLE_LOAD;
                        end else begin
                            state   <= BOUNCE;
                            gap_cnt <= next_gap;
                            lfsr    <= lfsr_next;
                        end
                    end
                end
                BOUNCE: begin
                    if (gap_cnt == GW'(1)) begin
                        out_q      <= ~out_q;
                        toggle_cnt <= toggle_cnt - TW'(1);
                        if (toggle_cnt == TW'(1)) begin
                            state      <= SETTLE;
                            settle_cnt <= SETTLE_LOAD;
                        end else begin
                            gap_cnt <= next_gap;
                            lfsr    <= lfsr_next;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt - SW'(1);
                    if (settle_cnt == SW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_out   = out_q;
    assign bus.o_ready = (state == IDLE);
    assign bus.o_busy  = (state == BOUNCE) || (state == SETTLE);
    assign bus.o_done  = (state == DONE);
endmodule

// File: tb/tb_button_emulator.sv
// Bench for button_emulator: a fixed-gap instance and a random-gap instance
// driven by directed commands. Expected toggle/done events are queued when a
// command is issued; a negedge monitor pops and compares them as they occur.
module tb_button_emulator;
    localparam int          BMAX     = 8;
    localparam int          NBW      = $clog2(BMAX + 1);
    localparam int          F_GAP    = 2;
    localparam int          F_SET    = 8;
    localparam int          R_GAP    = 6;
    localparam int          R_SET    = 16;
    localparam int          DEADZONE = 1024;
    localparam logic [15:0] SEED     = 16'hACE1;

    typedef struct {
        int dut;
        int edge_no;
        bit is_done;
        bit value;
    } ev_t;

    logic clk = 1'b0;
    int   edge_cnt = 0;

    logic           rst_a   [2];
    logic           valid_a [2];
    logic           level_a [2];
    logic [NBW-1:0] nb_a    [2];
    logic           out_a   [2];
    logic           ready_a [2];
    logic           busy_a  [2];
    logic           done_a  [2];

    ev_t         exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b0;
    logic        prev_out [2];
    int          last_tog [2];
    logic [15:0] m_lfsr   [2];
    logic        m_out    [2];
    int          m_free   [2];

    logic db_out  = 1'b0;
    int   db_cnt  = 0;
    int   db_rise = 0;
    int   db_fall = 0;

    button_emulator_if #(.BOUNCE_MAX(BMAX)) bus_f ();
    button_emulator_if #(.BOUNCE_MAX(BMAX)) bus_r ();

    assign bus_f.i_valid     = valid_a[0];
    assign bus_f.i_level     = level_a[0];
    assign bus_f.i_n_bounces = nb_a[0];
    assign bus_r.i_valid     = valid_a[1];
    assign bus_r.i_level     = level_a[1];
    assign bus_r.i_n_bounces = nb_a[1];

    assign out_a[0]   = bus_f.o_out;
    assign ready_a[0] = bus_f.o_ready;
    assign busy_a[0]  = bus_f.o_busy;
    assign done_a[0]  = bus_f.o_done;
    assign out_a[1]   = bus_r.o_out;
    assign ready_a[1] = bus_r.o_ready;
    assign busy_a[1]  = bus_r.o_busy;
    assign done_a[1]  = bus_r.o_done;

    button_emulator #(
        .BOUNCE_MAX(BMAX), .GAP_LOG2(F_GAP), .SETTLE_CYCLES(F_SET),
        .RANDOM(1'b0), .LFSR_SEED(SEED), .RESET_LEVEL(1'b0)
    ) dut_f (
        .clk(clk), .i_reset(rst_a[0]), .bus(bus_f)
    );

    button_emulator #(
        .BOUNCE_MAX(BMAX), .GAP_LOG2(R_GAP), .SETTLE_CYCLES(R_SET),
        .RANDOM(1'b1), .LFSR_SEED(SEED), .RESET_LEVEL(1'b0)
    ) dut_r (
        .clk(clk), .i_reset(rst_a[1]), .bus(bus_r)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Edge counter: during the cycle after rising edge k it reads k
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Debouncer model on the random instance: follows the line once stable for DEADZONE cycles
    always @(posedge clk) begin
        if (out_a[1] === db_out) begin
            db_cnt <= 0;
        end else if (db_cnt == DEADZONE - 1) begin
            db_out <= out_a[1];
            db_cnt <= 0;
            if (out_a[1] === 1'b1) db_rise <= db_rise + 1;
            else db_fall <= db_fall + 1;
        end else begin
            db_cnt <= db_cnt + 1;
        end
    end

    function automatic logic [15:0] lfsrNext(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic pushEvent(input int d, input int e, input bit is_done, input bit value);
        ev_t ev;
        ev.dut     = d;
        ev.edge_no = e;
        ev.is_done = is_done;
        ev.value   = value;
        exp_q.push_back(ev);
    endtask

    task automatic checkOutput(input string name, input logic actual, input logic required);
        n_cmp++;
        if (actual !== required) begin
            n_bad++;
            $display("[TB] FAIL %s at edge %0d: got %b, expected %b", name, edge_cnt, actual, required);
        end
    endtask

    task automatic scoreEvent(input int d, input bit is_done, input bit value);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("[TB] FAIL unexpected_event dut=%0d edge=%0d done=%0b out=%0b, expected no event",
                     d, edge_cnt, is_done, value);
        end else begin
            e = exp_q.pop_front();
            if (e.dut != d || e.edge_no != edge_cnt || e.is_done != is_done || e.value != value) begin
                n_bad++;
                $display("[TB] FAIL event got dut=%0d edge=%0d done=%0b out=%0b, expected dut=%0d edge=%0d done=%0b out=%0b",
                         d, edge_cnt, is_done, value, e.dut, e.edge_no, e.is_done, e.value);
            end
        end
    endtask

    // Monitor: on every line change or done pulse, pop and compare the next expected event
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                if (out_a[d] !== prev_out[d]) begin
                    scoreEvent(d, 1'b0, out_a[d]);
                    if (d == 1 && last_tog[1] >= 0) begin
                        n_cmp++;
                        if (edge_cnt - last_tog[1] < 1 || edge_cnt - last_tog[1] > (1 << R_GAP)) begin
                            n_bad++;
                            $display("[TB] FAIL gap_range got %0d cycles, expected 1..%0d",
                                     edge_cnt - last_tog[1], 1 << R_GAP);
                        end
                    end
                    last_tog[d] = edge_cnt;
                end
                if (done_a[d] === 1'b1) begin
                    scoreEvent(d, 1'b1, 1'b1);
                    last_tog[d] = -1;
                end
            end
        end
        prev_out[0] = out_a[0];
        prev_out[1] = out_a[1];
    end

    task automatic waitEdge(input int e);
        while (edge_cnt < e) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Issue one command once the model says the instance is idle and queue its expected events
    task automatic applyStimulus(input int d, input bit level, input int n, input bit keep_valid,
                                 output int acc);
        int   nc;
        int   t;
        int   tog;
        int   gap;
        logic cur;
        waitEdge(m_free[d]);
        checkOutput("ready_before_cmd", ready_a[d], 1'b1);
        acc = edge_cnt + 1;
        nc  = (n > BMAX) ? BMAX : n;
        t   = 2 * nc + ((level != m_out[d]) ? 1 : 0);
        tog = acc;
        cur = m_out[d];
        for (int j = 0; j < t; j++) begin
            gap = (d == 0) ? (1 << F_GAP) : (int'(m_lfsr[d][R_GAP-1:0]) + 1);
            m_lfsr[d] = lfsrNext(m_lfsr[d]);
            tog += gap;
            cur = ~cur;
            pushEvent(d, tog, 1'b0, cur);
        end
        tog += (d == 0) ? F_SET : R_SET;
        pushEvent(d, tog, 1'b1, 1'b1);
        m_free[d]  = tog + 1;
        m_out[d]   = level;
        valid_a[d] = 1'b1;
        level_a[d] = level;
        nb_a[d]    = NBW'(n);
        @(posedge clk);
        #2;
        if (!keep_valid) valid_a[d] = 1'b0;
        checkOutput("busy_after_accept", busy_a[d], 1'b1);
        checkOutput("ready_after_accept", ready_a[d], 1'b0);
    endtask

    // Watchdog so the run always terminates
    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired at edge %0d", edge_cnt);
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence
    initial begin
        int acc;
        rst_a    = '{1'b1, 1'b1};
        valid_a  = '{1'b1, 1'b1};
        level_a  = '{1'b1, 1'b1};
        nb_a     = '{NBW'(3), NBW'(3)};
        m_lfsr   = '{SEED, SEED};
        m_out    = '{1'b0, 1'b0};
        m_free   = '{0, 0};
        last_tog = '{-1, -1};

        // Reset held 3 cycles with a command offered
        repeat (3) @(posedge clk);
        #2;
        rst_a   = '{1'b0, 1'b0};
        valid_a = '{1'b0, 1'b0};
        for (int d = 0; d < 2; d++) begin
            checkOutput("reset_out", out_a[d], 1'b0);
            checkOutput("reset_ready", ready_a[d], 1'b1);
            checkOutput("reset_busy", busy_a[d], 1'b0);
            checkOutput("reset_done", done_a[d], 1'b0);
        end
        mon_en = 1'b1;

        // Fixed gaps: press n=1 (toggles at +4,+8,+12, done at +20), then no-change n=0 (done at +8)
        $display("[TB] fixed-gap press and no-change command");
        applyStimulus(0, 1'b1, 1, 1'b0, acc);
        applyStimulus(0, 1'b1, 0, 1'b0, acc);

        // Release n=1 interrupted by reset between toggles 2 and 3
        $display("[TB] reset mid-operation");
        applyStimulus(0, 1'b0, 1, 1'b0, acc);
        waitEdge(acc + 9);
        rst_a[0] = 1'b1;
        exp_q.delete();
        pushEvent(0, acc + 10, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_a[0] = 1'b0;
        checkOutput("midreset_out", out_a[0], 1'b0);
        checkOutput("midreset_ready", ready_a[0], 1'b1);
        checkOutput("midreset_busy", busy_a[0], 1'b0);
        m_out[0]  = 1'b0;
        m_lfsr[0] = SEED;
        m_free[0] = acc + 10;
        waitEdge(acc + 40);

        // Random gaps into the debouncer model: press then release, n=4 each
        $display("[TB] random-gap loopback press/release");
        applyStimulus(1, 1'b1, 4, 1'b0, acc);
        waitEdge(m_free[1] + DEADZONE + 80);
        checkOutput("db_level_after_press", db_out, 1'b1);
        checkOutput("db_one_rise", (db_rise == 1), 1'b1);
        applyStimulus(1, 1'b0, 4, 1'b0, acc);
        waitEdge(m_free[1] + DEADZONE + 80);
        checkOutput("db_level_after_release", db_out, 1'b0);
        checkOutput("db_rise_count", (db_rise == 1), 1'b1);
        checkOutput("db_fall_count", (db_fall == 1), 1'b1);

        // Clamp n=15 to 8 (17 toggles) with valid held through the bounce; next command waits for IDLE
        $display("[TB] clamp with valid held high");
        applyStimulus(1, 1'b1, 15, 1'b1, acc);
        applyStimulus(1, 1'b1, 0, 1'b0, acc);
        waitEdge(m_free[1] + 5);
        checkOutput("final_level", out_a[1], 1'b1);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL leftover_events got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
